// File: rtl/regfile_alu_pipe.sv
// Register file feeding a single-issue ALU with a result writeback stage and forwarding.
// Single-cycle ops produce a result the cycle after accept; div/mod iterate one bit per cycle.
module regfile_alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic [2:0]        op_i,
  output logic              out_valid_o,
  output logic [WIDTH-1:0]  a_out_o,
  output logic [WIDTH-1:0]  b_out_o,
  output logic [WIDTH-1:0]  w_out_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              dbz_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StPend, StDiv} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  regs_q [Depth];
  logic [WIDTH-1:0]  rd_a, rd_b, alu_res;
  logic              accept, is_div, div_done;

  logic [WIDTH-1:0]  dvd_q, dvs_q, quo_q, rem_q;
  logic [WIDTH-1:0]  quo_nx, rem_nx;
  logic [WIDTH:0]    rem_sh, rem_sub;
  logic              rem_ge;
  logic              is_mod_q;
  logic [ADDR_W-1:0] div_addr_q;
  logic [CntW-1:0]   cnt_q;

  logic              out_valid_q, dbz_q;
  logic [WIDTH-1:0]  a_q, b_q, w_q;
  logic [ADDR_W-1:0] waddr_q;

  assign accept = in_valid_i && in_ready_o;
  assign is_div = (op_i == 3'd3) || (op_i == 3'd4);

  // In StPend the array still holds the stale value; the pending result wins.
  always_comb begin
    rd_a = regs_q[ra_i];
    rd_b = regs_q[rb_i];
    if (state_q == StPend && waddr_q == ra_i) rd_a = w_q;
    if (state_q == StPend && waddr_q == rb_i) rd_b = w_q;
    if (ZERO_REG != 0 && ra_i == '0) rd_a = '0;
    if (ZERO_REG != 0 && rb_i == '0) rd_b = '0;
  end

  always_comb begin
    alu_res = '0;
    case (op_i)
      3'd0:    alu_res = rd_a + rd_b;
      3'd1:    alu_res = rd_a - rd_b;
      3'd2:    alu_res = rd_a * rd_b;
      3'd5:    alu_res = rd_a & rd_b;
      3'd6:    alu_res = rd_a | rd_b;
      3'd7:    alu_res = rd_a ^ rd_b;
      default: alu_res = '0;
    endcase
  end

  // Restoring divide step; a zero divisor naturally yields all-ones quotient, remainder = dividend.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    rem_ge  = rem_sh >= {1'b0, dvs_q};
    rem_nx  = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], rem_ge};
  end

  assign div_done = (state_q == StDiv) && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StPend: begin
        if (accept)                 state_d = is_div ? StDiv : StPend;
        else if (state_q == StPend) state_d = StIdle;
      end
      StDiv:   if (div_done) state_d = StPend;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b1;
    case (state_q)
      StDiv:   in_ready_o = 1'b0;
      default: in_ready_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) regs_q[i] <= WIDTH'(i);
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      is_mod_q    <= 1'b0;
      div_addr_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      waddr_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == StPend && !(ZERO_REG != 0 && waddr_q == '0)) regs_q[waddr_q] <= w_q;
      if (accept) begin
        if (is_div) begin
          dvd_q      <= rd_a;
          dvs_q      <= rd_b;
          quo_q      <= rd_a;
          rem_q      <= '0;
          cnt_q      <= '0;
          is_mod_q   <= (op_i == 3'd4);
          div_addr_q <= rw_i;
        end else begin
          out_valid_q <= 1'b1;
          a_q         <= rd_a;
          b_q         <= rd_b;
          w_q         <= alu_res;
          waddr_q     <= rw_i;
          dbz_q       <= 1'b0;
        end
      end else if (state_q == StDiv) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
        cnt_q <= cnt_q + CntW'(1);
        if (div_done) begin
          out_valid_q <= 1'b1;
          a_q         <= dvd_q;
          b_q         <= dvs_q;
          w_q         <= is_mod_q ? rem_nx : quo_nx;
          waddr_q     <= div_addr_q;
          dbz_q       <= (dvs_q == '0);
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign a_out_o     = a_q;
  assign b_out_o     = b_q;
  assign w_out_o     = w_q;
  assign w_addr_o    = waddr_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe; a second instance is built with ZERO_REG=1.
module tb_regfile_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  ra = '0, rb = '0, rw = '0;
  logic [2:0]  op = '0;

  logic        in_ready, out_valid, dbz;
  logic [31:0] a_out, b_out, w_out;
  logic [4:0]  w_addr;
  logic        z_in_ready, z_out_valid, z_dbz;
  logic [31:0] z_a_out, z_b_out, z_w_out;
  logic [4:0]  z_w_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_alu_pipe #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ra_i(ra), .rb_i(rb), .rw_i(rw), .op_i(op), .out_valid_o(out_valid),
    .a_out_o(a_out), .b_out_o(b_out), .w_out_o(w_out), .w_addr_o(w_addr), .dbz_o(dbz)
  );

  regfile_alu_pipe #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(z_in_ready),
    .ra_i(ra), .rb_i(rb), .rw_i(rw), .op_i(op), .out_valid_o(z_out_valid),
    .a_out_o(z_a_out), .b_out_o(z_b_out), .w_out_o(z_w_out), .w_addr_o(z_w_addr), .dbz_o(z_dbz)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge; returns at the negedge where out_valid is seen (or bound hit).
  task automatic exec(input logic [2:0] o, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] w, input bit poke, output int lat, output int busy);
    op = o; ra = a; rb = b; rw = w; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      if (poke && lat == 5) begin
        op = 3'd0; ra = 5'd0; rb = 5'd0; rw = 5'd11; in_valid = 1'b1;
      end
      if (poke && lat == 6) in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, busy, seen;

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_w_out", w_out, 0);
    check_eq("rst_a_out", a_out, 0);
    check_eq("rst_b_out", b_out, 0);
    check_eq("rst_w_addr", w_addr, 0);
    check_eq("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Build 0x80000000 in reg28 and multiply it by reg2=2.
    exec(3'd1, 5'd0, 5'd1, 5'd29, 0, lat, busy);
    check_eq("sub_wrap", w_out, 32'hFFFF_FFFF);
    exec(3'd3, 5'd29, 5'd2, 5'd28, 0, lat, busy);
    check_eq("div_half_lat", lat, 32);
    check_eq("div_half", w_out, 32'h7FFF_FFFF);
    exec(3'd1, 5'd28, 5'd29, 5'd28, 0, lat, busy);
    check_eq("sub_msb", w_out, 32'h8000_0000);
    exec(3'd2, 5'd28, 5'd2, 5'd30, 0, lat, busy);
    check_eq("mul_a", a_out, 32'h8000_0000);
    check_eq("mul_wrap", w_out, 32'h0);
    @(negedge clk);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exec(3'd0, 5'd18, 5'd31, 5'd1, 0, lat, busy);
    check_eq("add_valid", out_valid, 1);
    check_eq("add_w_out", w_out, 49);
    check_eq("add_w_addr", w_addr, 1);
    check_eq("add_a", a_out, 18);
    check_eq("add_b", b_out, 31);
    @(negedge clk);
    check_eq("hold_valid", out_valid, 0);
    check_eq("hold_w_out", w_out, 49);
    check_eq("hold_w_addr", w_addr, 1);
    exec(3'd0, 5'd1, 5'd0, 5'd3, 0, lat, busy);
    check_eq("reg1_read", a_out, 49);
    @(negedge clk);

    exec(3'd1, 5'd20, 5'd13, 5'd18, 0, lat, busy);
    check_eq("b2b_sub", w_out, 7);
    check_eq("b2b_ready1", in_ready, 1);
    exec(3'd0, 5'd18, 5'd18, 5'd2, 0, lat, busy);
    check_eq("b2b_lat", lat, 0);
    check_eq("b2b_fwd_a", a_out, 7);
    check_eq("b2b_fwd_b", b_out, 7);
    check_eq("b2b_add", w_out, 14);
    check_eq("b2b_ready2", in_ready, 1);
    @(negedge clk);

    exec(3'd3, 5'd29, 5'd9, 5'd10, 1, lat, busy);
    check_eq("div_lat", lat, 32);
    check_eq("div_busy", busy, 32);
    check_eq("div_q", w_out, 3);
    check_eq("div_dbz", dbz, 0);
    check_eq("div_w_addr", w_addr, 10);
    check_eq("div_a", a_out, 29);
    check_eq("div_b", b_out, 9);
    @(negedge clk);
    check_eq("div_pulse_end", out_valid, 0);
    exec(3'd0, 5'd10, 5'd11, 5'd12, 0, lat, busy);
    check_eq("reg10_read", a_out, 3);
    check_eq("poke_ignored", b_out, 11);

    exec(3'd4, 5'd22, 5'd0, 5'd27, 0, lat, busy);
    check_eq("mod0_w", w_out, 22);
    check_eq("mod0_dbz", dbz, 1);
    exec(3'd3, 5'd22, 5'd0, 5'd26, 0, lat, busy);
    check_eq("div0_w", w_out, 32'hFFFF_FFFF);
    check_eq("div0_dbz", dbz, 1);
    exec(3'd4, 5'd20, 5'd6, 5'd25, 0, lat, busy);
    check_eq("mod_w", w_out, 2);
    check_eq("mod_dbz", dbz, 0);
    @(negedge clk);

    // Abort a divide by reset; reg5 must keep its reset value.
    op = 3'd3; ra = 5'd29; rb = 5'd9; rw = 5'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("abort_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    exec(3'd0, 5'd5, 5'd0, 5'd6, 0, lat, busy);
    check_eq("reg5_kept", a_out, 5);

    exec(3'd7, 5'd7, 5'd3, 5'd0, 0, lat, busy);
    check_eq("z_xor_valid", z_out_valid, 1);
    check_eq("z_xor_w", z_w_out, 4);
    check_eq("nz_xor_w", w_out, 4);
    exec(3'd0, 5'd0, 5'd0, 5'd9, 0, lat, busy);
    check_eq("z_no_bypass", z_a_out, 0);
    check_eq("nz_bypass", a_out, 4);
    @(negedge clk);
    exec(3'd0, 5'd0, 5'd0, 5'd9, 0, lat, busy);
    check_eq("z_reg0", z_a_out, 0);
    check_eq("nz_reg0", a_out, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_alu_pipe.md
REGFILE_ALU_PIPE -- requirements
Module: regfile_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register, operand and result.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero and writes to it are discarded.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request this cycle.
REQ-008 ra, rb  in  ADDR_W  source register addresses.
REQ-009 rw  in  ADDR_W  destination register address.
REQ-010 op  in  3  0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor.
REQ-011 out_valid  out  1  one-cycle pulse: a result is presented.
REQ-012 a_out, b_out, w_out  out  WIDTH  operand A, operand B, result of the presented operation.
REQ-013 w_addr  out  ADDR_W  destination of the presented result.
REQ-014 dbz  out  1  divide/modulus by zero flag, valid with out_valid.

Function
REQ-015 Request accepted at a rising edge where in_valid=1 and in_ready=1; otherwise inputs ignored.
REQ-016 FSM states IDLE, PEND (one result awaiting writeback), DIV (iterating); in_ready=1 in IDLE and PEND, 0 in DIV.
REQ-017 Ops 0,1,2,5,6,7 at accept edge N: register operands, result, rw; out_valid=1 for the cycle after edge N; regfile[rw] written at edge N+1; state to PEND.
REQ-018 Arithmetic: unsigned, modulo 2**WIDTH; sub wraps; mul keeps the low WIDTH bits of the product.
REQ-019 Ops 3,4 at accept edge N: restoring shift-subtract divider, one quotient bit per cycle; state DIV; results, out_valid and dbz presented after edge N+WIDTH; regfile[rw] written at edge N+WIDTH+1; state to PEND at edge N+WIDTH.
REQ-020 Divisor zero: quotient all-ones, remainder = dividend, dbz=1 with the out_valid pulse; dbz=0 otherwise.
REQ-021 Forwarding: operand read whose address equals the pending writeback address returns the pending result, not the stale array value.
REQ-022 Back-to-back single-cycle ops sustain one accept per cycle; PEND with no new accept returns to IDLE after writeback.
REQ-023 ra=rb permitted; rw equal to ra or rb permitted, sources read pre-write (or forwarded) values.
REQ-024 ZERO_REG=1: reads of address 0 give zero, bypass to address 0 suppressed, write discarded; out_valid and w_out still produced.
REQ-025 Outputs a_out, b_out, w_out, w_addr hold last presented values when out_valid=0.

Reset
REQ-026 rst_n=0 asynchronously: state IDLE, in_ready=1 after release, out_valid=0, dbz=0, a_out=b_out=w_out=0, w_addr=0, divider counter cleared.
REQ-027 Register i resets to value i zero-extended (register 0 = 0).
REQ-028 Reset during DIV or PEND aborts the operation; no register write occurs.

Verification
REQ-029 After reset, add ra=18, rb=31, rw=1 -> next cycle out_valid=1, w_out=49, w_addr=1; register 1 reads 49 afterwards.
REQ-030 Back-to-back: sub ra=20, rb=13, rw=18, then next cycle add ra=18, rb=18, rw=2 -> results 7 then 14 (forwarded), in_ready held 1.
REQ-031 div ra=29, rb=9, rw=10 -> in_ready=0 for WIDTH cycles, out_valid after edge N+32 with w_out=3, dbz=0; in_valid pulsed during DIV is ignored.
REQ-032 mod ra=22, rb=0, rw=27 -> w_out=22, dbz=1; div ra=22, rb=0 -> w_out=0xFFFFFFFF, dbz=1.
REQ-033 mul reg28 (set to 0x80000000) by reg2=2 -> w_out=0 (wrap); sub 0-1 -> 0xFFFFFFFF.
REQ-034 Assert rst_n=0 mid-DIV targeting rw=5 -> no out_valid, register 5 reads 5; ZERO_REG=1 build: xor into rw=0 leaves register 0 reading 0.
